// File: rtl/multiplicacao_matrizes_seq.sv
// Sequential signed matrix multiplier C = A x B for square matrices of size
// 2x2 up to MAX_N x MAX_N. A single multiply-accumulate unit produces one
// product term per clock, so a job takes n^3 cycles of CALC plus one DONE cycle.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         job request, only sampled in IDLE
//   matrix_size   n-2 (00=2x2 .. 11=5x5)
//   A, B          packed signed operands, element (r,c) at index r*n+c
//   busy          high while the job is computing
//   done          one-cycle pulse when C / overflow_flag are final
//   C             packed result, elements at index >= n*n read as 0
//   overflow_flag sticky, set if any result element left the DATA_W range
module multiplicacao_matrizes_seq #(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 5,
    parameter int ACC_W  = 2*DATA_W+3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [1:0]                    matrix_size,
    input  logic [MAX_N*MAX_N*DATA_W-1:0] A,
    input  logic [MAX_N*MAX_N*DATA_W-1:0] B,
    output logic                          busy,
    output logic                          done,
    output logic [MAX_N*MAX_N*DATA_W-1:0] C,
    output logic                          overflow_flag
);
    localparam int NE = MAX_N*MAX_N;
    localparam int IW = $clog2(NE);
    localparam int CW = $clog2(MAX_N);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic signed [DATA_W-1:0] a_mem [NE];
    logic signed [DATA_W-1:0] b_mem [NE];
    logic        [DATA_W-1:0] c_mem [NE];
    logic [1:0]               size_q;
    logic [CW-1:0]            i, j, k;
    logic signed [ACC_W-1:0]  acc;

    logic [CW-1:0]             n_val, n_last;
    logic [IW-1:0]             a_idx, b_idx, c_idx;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   sum;
    logic [ACC_W-DATA_W:0]     sum_top;
    logic                      last_k, last_j, last_i, sum_ovf;

    always_comb begin
        n_val  = CW'(size_q) + CW'(2);
        n_last = CW'(size_q) + CW'(1);
        last_k = (k == n_last);
        last_j = (j == n_last);
        last_i = (i == n_last);
        a_idx  = IW'(i) * IW'(n_val) + IW'(k);
        b_idx  = IW'(k) * IW'(n_val) + IW'(j);
        c_idx  = IW'(i) * IW'(n_val) + IW'(j);
        prod   = a_mem[a_idx] * b_mem[b_idx];
        sum    = acc + ACC_W'(prod);
        // In range only if every bit from the DATA_W sign bit upward agrees.
        sum_top = sum[ACC_W-1:DATA_W-1];
        sum_ovf = !((&sum_top) || !(|sum_top));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: begin
                busy = 1'b1;
                if (last_k && last_j && last_i) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NE; e++) begin
                a_mem[e] <= '0;
                b_mem[e] <= '0;
                c_mem[e] <= '0;
            end
            size_q        <= '0;
            i             <= '0;
            j             <= '0;
            k             <= '0;
            acc           <= '0;
            overflow_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    for (int e = 0; e < NE; e++) begin
                        a_mem[e] <= A[e*DATA_W +: DATA_W];
                        b_mem[e] <= B[e*DATA_W +: DATA_W];
                        c_mem[e] <= '0;
                    end
                    size_q        <= matrix_size;
                    i             <= '0;
                    j             <= '0;
                    k             <= '0;
                    acc           <= '0;
                    overflow_flag <= 1'b0;
                end
                CALC: begin
                    if (!last_k) begin
                        acc <= sum;
                        k   <= k + CW'(1);
                    end else begin
                        // Element finished: wrap to DATA_W, flag out-of-range.
                        c_mem[c_idx] <= sum[DATA_W-1:0];
                        if (sum_ovf) overflow_flag <= 1'b1;
                        acc <= '0;
                        k   <= '0;
                        if (last_j) begin
                            j <= '0;
                            i <= last_i ? '0 : i + CW'(1);
                        end else begin
                            j <= j + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar e = 0; e < NE; e++) begin : g_c
        assign C[e*DATA_W +: DATA_W] = c_mem[e];
    end

endmodule

// File: tb/tb_multiplicacao_matrizes_seq.sv
module tb_multiplicacao_matrizes_seq;
    localparam int NE = 25;
    localparam int W  = 200;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   matrix_size = '0;
    logic [W-1:0] A = '0, B = '0;
    logic         busy, done, overflow_flag;
    logic [W-1:0] C;

    multiplicacao_matrizes_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .matrix_size(matrix_size),
        .A(A), .B(B), .busy(busy), .done(done), .C(C),
        .overflow_flag(overflow_flag)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int ma[NE], mb[NE];
    logic [W-1:0] exp_c;
    logic         exp_ovf;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Reference: textbook triple loop over row-major integer arrays.
    task automatic model(input int n);
        int s;
        exp_c   = '0;
        exp_ovf = 1'b0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                s = 0;
                for (int t = 0; t < n; t++) s += ma[r*n+t] * mb[t*n+c];
                if (s > 127 || s < -128) exp_ovf = 1'b1;
                exp_c[(r*n+c)*8 +: 8] = 8'(s);
            end
    endtask

    task automatic fill(input int av, input int bv);
        for (int e = 0; e < NE; e++) begin ma[e] = av; mb[e] = bv; end
    endtask

    task automatic fill_rand();
        for (int e = 0; e < NE; e++) begin
            ma[e] = int'($urandom_range(0, 255)) - 128;
            mb[e] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic drive_ops(input int n);
        for (int e = 0; e < NE; e++) begin
            A[e*8 +: 8] = 8'(ma[e]);
            B[e*8 +: 8] = 8'(mb[e]);
        end
        matrix_size = 2'(n - 2);
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge where done is seen.
    task automatic run_job(input int n, input string tag, input bit disturb);
        int done_cyc;
        model(n);
        drive_ops(n);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 300 && done_cyc == 0; cyc++) begin
            if (cyc == 1) begin
                chk({tag, ".busy"}, W'(busy), W'(1));
                chk({tag, ".ovf_clr"}, W'(overflow_flag), W'(0));
            end
            if (disturb && cyc == 10) begin
                A = ~A;
                B = {W{1'b1}};
                matrix_size = ~matrix_size;
                start = 1'b1;
            end
            if (disturb && cyc == 11) start = 1'b0;
            if (done) done_cyc = cyc;
            else @(negedge clk);
        end
        chk({tag, ".latency"}, W'(done_cyc), W'(n*n*n + 1));
        chk({tag, ".C"}, C, exp_c);
        chk({tag, ".ovf"}, W'(overflow_flag), W'(exp_ovf));
        chk({tag, ".busy_done"}, W'(busy), W'(0));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst.busy", W'(busy), W'(0));
        chk("rst.done", W'(done), W'(0));
        chk("rst.C", C, '0);
        chk("rst.ovf", W'(overflow_flag), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 2x2 known product; garbage beyond n*n must be ignored.
        for (int e = 0; e < NE; e++) begin ma[e] = e*7 - 50; mb[e] = 90 - e*5; end
        ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 4;
        mb[0] = 5; mb[1] = 6; mb[2] = 7; mb[3] = 8;
        run_job(2, "n2", 1'b0);
        chk("n2.const", C, W'(32'h322B_1613));
        @(negedge clk);

        // 3x3 with a wrapping element.
        fill(0, 0);
        for (int e = 0; e < 9; e++) begin ma[e] = e + 1; mb[e] = 9 - e; end
        run_job(3, "n3", 1'b0);
        chk("n3.c20", W'(C[6*8 +: 8]), W'(8'h8A));
        @(negedge clk);

        // Extreme operands: wrap, no saturation.
        fill(127, 127);
        run_job(5, "n5max", 1'b0);
        chk("n5max.const", C, {W{1'b0}} | {25{8'h05}});
        @(negedge clk);
        fill(-128, 1);
        run_job(5, "n5min", 1'b0);
        chk("n5min.const", C, {W{1'b0}} | {25{8'h80}});
        @(negedge clk);

        // Operands / size / start disturbed mid-job must not matter.
        fill_rand();
        run_job(4, "n4dist", 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("n4dist.idle_busy", W'(busy), W'(0));
            chk("n4dist.idle_done", W'(done), W'(0));
        end

        // Reset in the middle of a job.
        fill(127, 127);
        drive_ops(5);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid.C_partial_nz", W'(C != '0), W'(1));
        rst_n = 1'b0;
        #1;
        chk("mid.busy", W'(busy), W'(0));
        chk("mid.done", W'(done), W'(0));
        chk("mid.C", C, '0);
        chk("mid.ovf", W'(overflow_flag), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_rand();
        run_job(3, "post_rst", 1'b0);
        @(negedge clk);

        // Overflowed job then case-1 job started in the cycle after done.
        fill(127, 127);
        run_job(5, "b2b_ovf", 1'b0);
        @(negedge clk);
        fill(0, 0);
        ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 4;
        mb[0] = 5; mb[1] = 6; mb[2] = 7; mb[3] = 8;
        run_job(2, "b2b_n2", 1'b0);
        @(negedge clk);

        // Random back-to-back jobs.
        for (int t = 0; t < 8; t++) begin
            fill_rand();
            run_job(int'($urandom_range(2, 5)), "rand", 1'b0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multiplicacao_matrizes_seq.md
Name: multiplicacao_matrizes_seq

Overview:
- Sequential controller and datapath that computes C = A x B for square signed 8-bit matrices of size 2x2 to 5x5.
- Uses one shared multiply-accumulate unit, sequenced by an FSM, and produces one product term per clock cycle.
- Matrix packing, size code and overflow semantics match the combinational multiplicacao_matrizes block, so the two are interchangeable behind a start/done handshake.
- Intended for area-constrained builds where 25 parallel dot-products are too costly.

Parameters:
DATA_W, 8, signed element width
MAX_N, 5, maximum matrix dimension; packed buses hold MAX_N*MAX_N elements
ACC_W, 2*DATA_W+3 (19), signed accumulator width; must hold MAX_N*(-2^(DATA_W-1))^2 without overflow

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a multiply; sampled only in IDLE
matrix_size  input  2  00=2x2, 01=3x3, 10=4x4, 11=5x5; n = matrix_size+2
A  input  MAX_N*MAX_N*DATA_W (200)  packed signed matrix A
B  input  MAX_N*MAX_N*DATA_W (200)  packed signed matrix B
busy  output  1  high while computing
done  output  1  one-cycle pulse when C and overflow_flag are final
C  output  MAX_N*MAX_N*DATA_W (200)  packed result
overflow_flag  output  1  sticky; set if any result element is out of the DATA_W signed range

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low.
- Reset values: state=IDLE; busy=0; done=0; C=0; overflow_flag=0; i, j, k and acc all 0.
- Packing: element (r,c) is at index r*n+c and occupies bits [8*idx+7 : 8*idx]. Packing is compact for every n; elements at indices >= n*n are ignored on input and driven 0 on C.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If start=1 on a clock edge: latch A, B and matrix_size into internal registers; clear C, overflow_flag, acc, i, j and k; go to CALC.
  - Otherwise stay in IDLE.
- CALC (busy=1):
  - Each cycle, compute sum = acc + A[i][k]*B[k][j] (full-precision signed, ACC_W bits).
  - If k < n-1: acc <= sum; k <= k+1.
  - If k == n-1:
    - C[i][j] <= sum[DATA_W-1:0] (two's-complement wrap).
    - If sum > 127 or sum < -128, set overflow_flag (sticky until next accepted start).
    - acc <= 0; k <= 0; advance j, and on j wrap advance i.
    - After element (n-1,n-1), go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency: CALC lasts n^3 cycles, so done is high in the (n^3+1)th cycle after the start edge: 9, 28, 65 and 126 cycles for n=2..5.
- Output holding: C and overflow_flag are stable from DONE until the next accepted start. Partial C values are visible during CALC but are not valid.
- start while busy or during DONE is ignored; no queuing.
- Changes to A, B or matrix_size after the start edge have no effect on the current job.
- Back-to-back: start asserted in the cycle after DONE (in IDLE) is accepted normally.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.

Test Plan:
1. n=2, A=[1,2;3,4], B=[5,6;7,8]
   -> C=[19,22;43,50], overflow_flag=0, done pulses 9 cycles after the start edge, C[199:32]=0.
2. n=3, A=[1..9], B=[9..1] row-major
   -> C=[30,24,18;84,69,54;-118(0x8A),114,90], overflow_flag=1 (138 wraps), done at 28 cycles.
3. n=5, A all 127, B all 127
   -> each sum=80645, C all 0x05, overflow_flag=1, done at 126 cycles.
   Then n=5, A all -128, B all 1
   -> C all 0x80, overflow_flag=1; confirms no accumulator saturation.
4. Start n=4, change A/B/matrix_size and pulse start during CALC
   -> result matches the originally latched operands, single done at 65 cycles, no second job.
5. Assert rst_n=0 for 1 cycle mid-CALC
   -> busy, done, C and overflow_flag go to 0 asynchronously; a fresh start then yields the correct result.
6. Overflowed job followed immediately by the case 1 job (start in the cycle after done)
   -> overflow_flag cleared on accept, case 1 results and timing reproduced exactly.
